// File: rtl/cr_prefix_ins_pkg.sv
// Shared types and constants for the prefix-insertion block.
package cr_prefix_insPKG;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PFX  = 2'd1,
    ST_PASS = 2'd2
  } state_e;

  localparam int STAT_FRAME    = 0;
  localparam int STAT_PFX_WORD = 1;
  localparam int N_STAT        = 2;

  // Width of a counter holding 0..max_pfx inclusive.
  function automatic int pl_w(input int max_pfx);
    return (max_pfx < 1) ? 1 : $clog2(max_pfx + 1);
  endfunction

endpackage

// File: rtl/cr_prefix_ins_err_agg.sv
// Sticky error latch with masked, registered interrupt.
module cr_prefix_err_agg #(
  parameter int N_ERR = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_ERR-1:0] err_in,
  input  logic [N_ERR-1:0] err_clr,
  input  logic [N_ERR-1:0] err_mask,
  output logic [N_ERR-1:0] err_sticky,
  output logic             int_o
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sticky <= '0;
      int_o      <= 1'b0;
    end else begin
      // set has priority over a coincident clear
      err_sticky <= (err_sticky & ~err_clr) | err_in;
      int_o      <= |(err_sticky & err_mask);
    end
  end

endmodule

// File: rtl/cr_prefix_ins.sv
// Stream prefix inserter: prepends up to MAX_PFX configured words to each frame.
module cr_prefix_ins
  import cr_prefix_insPKG::*;
#(
  parameter  int DATA_W  = 64,
  parameter  int MAX_PFX = 16,
  parameter  int N_ERR   = 6,
  localparam int PL_W    = pl_w(MAX_PFX)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_enable,
  input  logic [PL_W-1:0]           cfg_pfx_len,
  input  logic [MAX_PFX*DATA_W-1:0] cfg_pfx_data,
  input  logic                      ib_tvalid,
  input  logic [DATA_W-1:0]         ib_tdata,
  input  logic                      ib_tlast,
  output logic                      ib_tready,
  output logic                      ob_tvalid,
  output logic [DATA_W-1:0]         ob_tdata,
  output logic                      ob_tlast,
  output logic                      ob_tsop,
  input  logic                      ob_tready,
  input  logic [N_ERR-1:0]          err_in,
  input  logic [N_ERR-1:0]          err_clr,
  input  logic [N_ERR-1:0]          err_mask,
  output logic [N_ERR-1:0]          err_sticky,
  output logic                      int_o,
  output logic                      stat_frame,
  output logic                      stat_pfx_word
);

  state_e                    state_q, state_d;
  logic [PL_W-1:0]           len_q, idx_q, len_c;
  logic [MAX_PFX*DATA_W-1:0] pdata_q;
  logic                      sop_pend_q, ob_pfx_q;
  logic                      drain, ld_pfx, ld_data, snap;
  logic [N_STAT-1:0]         stat_q;

  assign len_c = (cfg_pfx_len > PL_W'(MAX_PFX)) ? PL_W'(MAX_PFX) : cfg_pfx_len;
  assign drain = !ob_tvalid || ob_tready;

  always_comb begin
    state_d   = state_q;
    ld_pfx    = 1'b0;
    ld_data   = 1'b0;
    snap      = 1'b0;
    ib_tready = 1'b0;
    case (state_q)
      ST_IDLE: if (ib_tvalid) begin
        if (cfg_enable && len_c != '0) begin
          snap    = 1'b1;
          state_d = ST_PFX;
        end else begin
          state_d = ST_PASS;
        end
      end
      ST_PFX: if (drain) begin
        ld_pfx = 1'b1;
        if (idx_q == len_q - PL_W'(1)) state_d = ST_PASS;
      end
      ST_PASS: begin
        ib_tready = rst_n && drain;
        ld_data   = ib_tvalid && ib_tready;
        if (ld_data && ib_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q      <= '0;
      idx_q      <= '0;
      pdata_q    <= '0;
      sop_pend_q <= 1'b0;
      ob_pfx_q   <= 1'b0;
      ob_tvalid  <= 1'b0;
      ob_tdata   <= '0;
      ob_tlast   <= 1'b0;
      ob_tsop    <= 1'b0;
      stat_q     <= '0;
    end else begin
      stat_q[STAT_FRAME]    <= ob_tvalid && ob_tready && ob_tlast;
      stat_q[STAT_PFX_WORD] <= ob_tvalid && ob_tready && ob_pfx_q;
      if (ob_tready) ob_tvalid <= 1'b0;
      // a frame without prefix marks its first data beat as sop
      if (state_q == ST_IDLE) sop_pend_q <= 1'b1;
      if (snap) begin
        len_q   <= len_c;
        pdata_q <= cfg_pfx_data;
        idx_q   <= '0;
      end
      if (ld_pfx) begin
        ob_tvalid  <= 1'b1;
        ob_tdata   <= pdata_q[int'(idx_q)*DATA_W +: DATA_W];
        ob_tlast   <= 1'b0;
        ob_tsop    <= (idx_q == '0);
        ob_pfx_q   <= 1'b1;
        idx_q      <= idx_q + PL_W'(1);
        sop_pend_q <= 1'b0;
      end
      if (ld_data) begin
        ob_tvalid  <= 1'b1;
        ob_tdata   <= ib_tdata;
        ob_tlast   <= ib_tlast;
        ob_tsop    <= sop_pend_q;
        ob_pfx_q   <= 1'b0;
        sop_pend_q <= 1'b0;
      end
    end
  end

  assign stat_frame    = stat_q[STAT_FRAME];
  assign stat_pfx_word = stat_q[STAT_PFX_WORD];

  cr_prefix_err_agg #(.N_ERR(N_ERR)) u_err (
    .clk        (clk),
    .rst_n      (rst_n),
    .err_in     (err_in),
    .err_clr    (err_clr),
    .err_mask   (err_mask),
    .err_sticky (err_sticky),
    .int_o      (int_o)
  );

endmodule

// File: tb/tb_cr_prefix_ins.sv
// Bench for cr_prefix_ins: frame-level reference model, random frames and backpressure.
module tb_cr_prefix_ins;

  localparam int DW  = 64;
  localparam int MP  = 16;
  localparam int NE  = 6;
  localparam int PLW = 5;

  logic            clk, rst_n;
  logic            cfg_enable;
  logic [PLW-1:0]  cfg_pfx_len;
  logic [MP*DW-1:0] cfg_pfx_data;
  logic            ib_tvalid, ib_tlast, ib_tready;
  logic [DW-1:0]   ib_tdata;
  logic            ob_tvalid, ob_tlast, ob_tsop, ob_tready;
  logic [DW-1:0]   ob_tdata;
  logic [NE-1:0]   err_in, err_clr, err_mask, err_sticky;
  logic            int_o, stat_frame, stat_pfx_word;

  cr_prefix_ins #(.DATA_W(DW), .MAX_PFX(MP), .N_ERR(NE)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_enable(cfg_enable), .cfg_pfx_len(cfg_pfx_len), .cfg_pfx_data(cfg_pfx_data),
    .ib_tvalid(ib_tvalid), .ib_tdata(ib_tdata), .ib_tlast(ib_tlast), .ib_tready(ib_tready),
    .ob_tvalid(ob_tvalid), .ob_tdata(ob_tdata), .ob_tlast(ob_tlast), .ob_tsop(ob_tsop),
    .ob_tready(ob_tready),
    .err_in(err_in), .err_clr(err_clr), .err_mask(err_mask), .err_sticky(err_sticky),
    .int_o(int_o), .stat_frame(stat_frame), .stat_pfx_word(stat_pfx_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rmode = 0;

  // expected beats (written by the stimulus) and observed beats (written by the monitor)
  logic [DW-1:0] exp_d[$];
  bit            exp_l[$], exp_s[$];
  logic [DW-1:0] got_d[$];
  bit            got_l[$], got_s[$];
  int            rd = 0;
  int            n_frame = 0, n_pfx = 0, stab_bad = 0;
  logic          held = 1'b0;
  logic [DW-1:0] h_d;
  logic          h_l, h_s;

  always @(posedge clk) begin
    if (rst_n && ob_tvalid && ob_tready) begin
      got_d.push_back(ob_tdata);
      got_l.push_back(ob_tlast);
      got_s.push_back(ob_tsop);
    end
    if (stat_frame)    n_frame <= n_frame + 1;
    if (stat_pfx_word) n_pfx   <= n_pfx + 1;
    if (rst_n && held && (!ob_tvalid || ob_tdata !== h_d || ob_tlast !== h_l || ob_tsop !== h_s))
      stab_bad <= stab_bad + 1;
    held <= rst_n && ob_tvalid && !ob_tready;
    h_d  <= ob_tdata;
    h_l  <= ob_tlast;
    h_s  <= ob_tsop;
  end

  initial begin
    ob_tready = 1'b1;
    forever begin
      @(negedge clk);
      case (rmode)
        0:       ob_tready = 1'b1;
        1:       ob_tready = ~ob_tready;
        2:       ob_tready = 1'($urandom % 2);
        default: ob_tready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input bit en, input int len);
    return en ? ((len > MP) ? MP : len) : 0;
  endfunction

  // Drives one frame starting at a negedge; queues the model's expected beats.
  task automatic send_frame(input int nb, input bit en, input int len, input int chg,
                            output int fs, output int ls);
    logic [MP*DW-1:0] pd;
    logic [DW-1:0]    dq[$];
    int eff, st;
    bit acc;
    for (int k = 0; k < MP; k++) pd[k*DW +: DW] = {$urandom, $urandom};
    cfg_enable   = en;
    cfg_pfx_len  = PLW'(len);
    cfg_pfx_data = pd;
    eff = eff_len(en, len);
    for (int k = 0; k < eff; k++) begin
      exp_d.push_back(pd[k*DW +: DW]); exp_l.push_back(1'b0); exp_s.push_back(k == 0);
    end
    for (int b = 0; b < nb; b++) begin
      dq.push_back({$urandom, $urandom});
      exp_d.push_back(dq[b]); exp_l.push_back(b == nb-1); exp_s.push_back(eff == 0 && b == 0);
    end
    fs = 0; ls = 0;
    for (int b = 0; b < nb; b++) begin
      ib_tvalid = 1'b1; ib_tdata = dq[b]; ib_tlast = (b == nb-1);
      st = 0; acc = 1'b0;
      forever begin
        #1;
        acc = ib_tready;
        @(posedge clk);
        @(negedge clk);
        if (acc) break;
        st++;
        if (st > 300) break;
      end
      if (!acc) begin
        chk("in_accept_timeout", 64'(acc), 64'd1);
        ib_tvalid = 1'b0;
        return;
      end
      if (b == 0) fs = st; else ls += st;
      if (b == 0 && chg >= 0) begin
        cfg_pfx_len = PLW'(chg);
        for (int k = 0; k < MP; k++) cfg_pfx_data[k*DW +: DW] = {$urandom, $urandom};
      end
    end
    ib_tvalid = 1'b0; ib_tlast = 1'b0;
  endtask

  task automatic check_out(input string tag);
    int w = 0;
    while (got_d.size() < exp_d.size() && w < 500) begin @(negedge clk); w++; end
    repeat (2) @(negedge clk);
    chk({tag, "_count"}, 64'(got_d.size()), 64'(exp_d.size()));
    for (int i = rd; i < exp_d.size(); i++) begin
      if (i < got_d.size()) begin
        chk({tag, "_data"}, got_d[i], exp_d[i]);
        chk({tag, "_last"}, 64'(got_l[i]), 64'(exp_l[i]));
        chk({tag, "_sop"},  64'(got_s[i]), 64'(exp_s[i]));
      end
    end
    rd = exp_d.size();
  endtask

  initial begin
    int fs, ls, bf, bp, eff, len, nb, chg;
    bit en;
    logic [NE-1:0] st_m, msk;
    logic          int_m;
    logic [DW-1:0] p0;

    rst_n = 1'b0; cfg_enable = 1'b0; cfg_pfx_len = '0; cfg_pfx_data = '0;
    ib_tvalid = 1'b0; ib_tdata = '0; ib_tlast = 1'b0;
    err_in = '0; err_clr = '0; err_mask = '0;
    repeat (2) @(negedge clk);
    chk("rst_ob_tvalid", 64'(ob_tvalid), 0);
    chk("rst_ib_tready", 64'(ib_tready), 0);
    chk("rst_sticky",    64'(err_sticky), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // two-word prefix, three data beats, full throughput
    bf = n_frame; bp = n_pfx;
    send_frame(3, 1'b1, 2, -1, fs, ls);
    check_out("pfx2");
    chk("pfx2_first_wait", 64'(fs), 3);
    chk("pfx2_pass_stall", 64'(ls), 0);
    chk("pfx2_stat_pfx",   64'(n_pfx - bp), 2);
    chk("pfx2_stat_frame", 64'(n_frame - bf), 1);

    // disabled, single beat: sop and last on the same beat
    bf = n_frame; bp = n_pfx;
    send_frame(1, 1'b0, 7, -1, fs, ls);
    check_out("single");
    chk("single_first_wait", 64'(fs), 1);
    chk("single_stat_pfx",   64'(n_pfx - bp), 0);
    chk("single_stat_frame", 64'(n_frame - bf), 1);

    // toggling backpressure
    rmode = 1;
    send_frame(4, 1'b1, 3, -1, fs, ls);
    check_out("toggle");
    rmode = 0;
    @(negedge clk);

    // mid-frame cfg change applies only to the next frame; oversize length clamps
    send_frame(3, 1'b1, 2, 5, fs, ls);
    check_out("chg_cur");
    bp = n_pfx;
    send_frame(2, 1'b1, 5, -1, fs, ls);
    check_out("chg_next");
    chk("chg_next_stat_pfx", 64'(n_pfx - bp), 5);
    bp = n_pfx;
    send_frame(2, 1'b1, 20, -1, fs, ls);
    check_out("clamp");
    chk("clamp_stat_pfx",   64'(n_pfx - bp), 16);
    chk("clamp_first_wait", 64'(fs), 17);

    // set beats clear on a coincident strobe; interrupt lags sticky by one cycle
    err_mask = 6'b001000; err_in = 6'b001000; err_clr = 6'b001000;
    @(posedge clk); @(negedge clk);
    err_in = '0; err_clr = '0;
    chk("err_set_wins", 64'(err_sticky), 64'h08);
    chk("err_int_lag",  64'(int_o), 0);
    @(negedge clk);
    chk("err_int_set",  64'(int_o), 1);
    err_clr = 6'b001000;
    @(posedge clk); @(negedge clk);
    err_clr = '0;
    chk("err_cleared",  64'(err_sticky), 0);
    @(negedge clk);
    chk("err_int_clr",  64'(int_o), 0);

    // random error traffic against the set/clear/mask rules
    err_clr = '1; @(posedge clk); @(negedge clk); err_clr = '0;
    st_m = '0;
    for (int i = 0; i < 30; i++) begin
      err_in  = NE'($urandom & $urandom);
      err_clr = NE'($urandom);
      msk     = NE'($urandom);
      err_mask = msk;
      int_m = |(st_m & msk);
      st_m  = (st_m & ~err_clr) | err_in;
      @(posedge clk); @(negedge clk);
      chk("rnd_sticky", 64'(err_sticky), 64'(st_m));
      chk("rnd_int",    64'(int_o), 64'(int_m));
    end
    err_in = '0; err_clr = '0;

    // reset while stalled in the prefix phase
    rmode = 3;
    @(negedge clk);
    cfg_enable = 1'b1; cfg_pfx_len = 3;
    for (int k = 0; k < MP; k++) cfg_pfx_data[k*DW +: DW] = {$urandom, $urandom};
    p0 = cfg_pfx_data[DW-1:0];
    ib_tvalid = 1'b1; ib_tdata = {$urandom, $urandom}; ib_tlast = 1'b0; err_in = '1;
    @(posedge clk); @(negedge clk);
    err_in = '0;
    @(posedge clk); @(negedge clk);
    chk("pfx_ib_tready", 64'(ib_tready), 0);
    chk("pfx_held_vld",  64'(ob_tvalid), 1);
    chk("pfx_held_sop",  64'(ob_tsop), 1);
    chk("pfx_held_data", ob_tdata, p0);
    rst_n = 1'b0; ib_tvalid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_vld",    64'(ob_tvalid), 0);
    chk("mid_rst_data",   ob_tdata, 0);
    chk("mid_rst_last",   64'(ob_tlast), 0);
    chk("mid_rst_sop",    64'(ob_tsop), 0);
    chk("mid_rst_sticky", 64'(err_sticky), 0);
    chk("mid_rst_int",    64'(int_o), 0);
    chk("mid_rst_stat",   64'({stat_frame, stat_pfx_word}), 0);
    chk("mid_rst_ready",  64'(ib_tready), 0);
    rst_n = 1'b1;
    rmode = 0;
    @(negedge clk);
    bp = n_pfx;
    send_frame(2, 1'b1, 3, -1, fs, ls);
    check_out("post_rst");
    chk("post_rst_first_wait", 64'(fs), 4);
    chk("post_rst_stat_pfx",   64'(n_pfx - bp), 3);

    // random frames under random backpressure
    for (int f = 0; f < 15; f++) begin
      en    = ($urandom % 4) != 0;
      len   = $urandom_range(0, 20);
      nb    = $urandom_range(1, 6);
      chg   = ($urandom % 3 == 0) ? $urandom_range(0, 20) : -1;
      rmode = $urandom_range(0, 2);
      @(negedge clk);
      eff = eff_len(en, len);
      bf = n_frame; bp = n_pfx;
      send_frame(nb, en, len, chg, fs, ls);
      check_out("rnd");
      chk("rnd_stat_frame", 64'(n_frame - bf), 1);
      chk("rnd_stat_pfx",   64'(n_pfx - bp), 64'(eff));
      if (rmode == 0) chk("rnd_first_wait", 64'(fs), 64'(eff + 1));
    end

    chk("held_stable", 64'(stab_bad), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cr_prefix_ins.md
CR_PREFIX_INS -- requirements
Module: cr_prefix_ins

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning stream data width in bits.
REQ-002 SHALL have parameter MAX_PFX, default 16, meaning maximum prefix words per frame.
REQ-003 SHALL have parameter N_ERR, default 6, meaning number of error sources aggregated.
REQ-004 Ports SHALL be:
- clk  in  1  single clock.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_enable  in  1  prefix insertion enable.
- cfg_pfx_len  in  PL_W  prefix word count 0..MAX_PFX, where PL_W = clog2(MAX_PFX+1).
- cfg_pfx_data  in  MAX_PFX*DATA_W  prefix words; word k occupies bits [k*DATA_W +: DATA_W].
- ib_tvalid/ib_tdata/ib_tlast  in  1/DATA_W/1  input stream.
- ib_tready  out  1  input accept.
- ob_tvalid/ob_tdata/ob_tlast/ob_tsop  out  1/DATA_W/1/1  output stream; ob_tsop marks the first beat of a frame.
- ob_tready  in  1  output accept.
- err_in  in  N_ERR  error pulses.
- err_clr  in  N_ERR  write-1-to-clear strobes.
- err_mask  in  N_ERR  1 = enabled for interrupt.
- err_sticky  out  N_ERR  latched error status.
- int_o  out  1  aggregated interrupt.
- stat_frame  out  1  one-cycle pulse per frame completed on the output.
- stat_pfx_word  out  1  one-cycle pulse per prefix word transferred.

Function
REQ-005 A beat transfers when valid and ready are both high on a rising edge of clk; no other event counts as a transfer.
REQ-006 Outputs SHALL come from a single register stage; ob_tvalid, once high, SHALL hold with ob_tdata/ob_tlast/ob_tsop stable until ob_tready is high.
REQ-007 The FSM SHALL have three states: IDLE, PFX and PASS.
REQ-008 In IDLE, when ib_tvalid is high: if cfg_enable=1 and cfg_pfx_len>0, the block SHALL snapshot len and data and go to PFX; otherwise it SHALL go to PASS. IDLE consumes no input beat.
REQ-009 In PFX, word k SHALL be loaded into the output register when it is empty or draining; after word len-1 is loaded the FSM SHALL go to PASS.
REQ-010 In PASS, ib_tready SHALL equal (!ob_tvalid | ob_tready); each accepted beat SHALL be copied to the output; when the accepted beat has ib_tlast=1 the FSM SHALL return to IDLE.
REQ-011 ib_tready SHALL be 0 in IDLE and PFX.
REQ-012 Prefix words SHALL have ob_tlast=0; ob_tsop SHALL be 1 only on the first output beat of a frame (prefix word 0, or data beat 0 when no prefix).
REQ-013 Changes on cfg_* after the snapshot SHALL NOT affect the frame in progress.
REQ-014 cfg_pfx_len > MAX_PFX SHALL be clamped to MAX_PFX.
REQ-015 A single-beat frame SHALL carry both ob_tsop=1 and ob_tlast=1 when no prefix is inserted.
REQ-016 Throughput SHALL be one beat per cycle with ob_tready held high; latency from input accept to ob_tvalid is 1 cycle.
REQ-017 err_sticky[i] SHALL set on err_in[i] and clear on err_clr[i]; when both occur in the same cycle, set SHALL win.
REQ-018 int_o SHALL be registered as |(err_sticky & err_mask), one cycle after err_sticky.
REQ-019 stat_frame SHALL pulse on transfer of an output beat with ob_tlast=1; stat_pfx_word SHALL pulse on transfer of a prefix beat.

Reset
REQ-020 While rst_n=0 at a clk edge: the FSM SHALL go to IDLE, and ob_tvalid, ob_tlast, ob_tsop, ob_tdata, err_sticky, int_o, stat_* and ib_tready SHALL all be 0.
REQ-021 Reset during a frame SHALL discard the frame; the first beat after reset SHALL be treated as the start of a new frame.

Structure
REQ-022 The state enum, PL_W computation and stat index constants SHALL live in a shared package cr_prefix_insPKG.
REQ-023 Error aggregation SHALL be a sub-module cr_prefix_err_agg, parametrised by N_ERR.

Verification
REQ-024 len=2, enable=1, 3-beat frame D0..D2, ob_tready=1 -> output P0(sop),P1,D0,D1,D2(last); stat_pfx_word pulses twice; stat_frame pulses once.
REQ-025 enable=0, 1-beat frame -> one output beat with sop=1 and last=1; no prefix pulses.
REQ-026 len=3, ob_tready toggled 0/1 every cycle -> no data loss or duplication; held beats remain stable.
REQ-027 cfg_pfx_len changed from 2 to 5 mid-frame -> current frame gets 2 prefix words; the next frame gets 5; len=20 with MAX_PFX=16 -> 16 words.
REQ-028 err_in[3] and err_clr[3] in the same cycle with mask[3]=1 -> err_sticky[3]=1, int_o=1 the following cycle; err_clr[3] alone -> both return to 0.
REQ-029 rst_n=0 for one cycle during PFX -> all outputs 0; the next frame starts with sop and a full prefix.
